// File: rtl/conv_multich_accel_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the
// multi-channel 5x5 convolution engine.
package conv_pkg;

   localparam int unsigned K            = 5;
   localparam int unsigned KK           = 25;
   localparam int unsigned CFG_BIAS_IDX = 25;
   localparam int unsigned SAT_W        = 64;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      COMPUTE,
      DRAIN
   } conv_state_e;

   // Accumulator width: wide enough for the tap sum and a full 32-bit bias.
   function automatic int unsigned acc_w(input int unsigned sum_w);
      return ((sum_w > 32) ? sum_w : 32) + 1;
   endfunction

   // Clamp a signed value into the signed range of out_w bits.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] v,
      input int unsigned             out_w
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/conv_multich_accel_if.sv
// Pixel stream, config port and result stream of the convolution engine.
// slave = engine side, master = source/sink side.
interface conv_multich_accel_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OUT_WIDTH  = 32,
   parameter int unsigned CH_W       = 2
);
   logic                        in_valid;
   logic                        in_ready;
   logic [DATA_WIDTH-1:0]       pixel_in;
   logic                        cfg_we;
   logic [CH_W-1:0]             cfg_ch;
   logic [4:0]                  cfg_idx;
   logic [31:0]                 cfg_data;
   logic                        cfg_err;
   logic                        frame_busy;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [OUT_WIDTH-1:0] out_data;
   logic [CH_W-1:0]             out_ch;
   logic                        out_last;

   modport slave (
      input  in_valid, pixel_in, cfg_we, cfg_ch, cfg_idx, cfg_data, out_ready,
      output in_ready, cfg_err, frame_busy, out_valid, out_data, out_ch, out_last
   );

   modport master (
      output in_valid, pixel_in, cfg_we, cfg_ch, cfg_idx, cfg_data, out_ready,
      input  in_ready, cfg_err, frame_busy, out_valid, out_data, out_ch, out_last
   );
endinterface

// File: rtl/conv_multich_accel_line_buffer.sv
// Four row delay lines plus a 5x5 shift window; exposes the window as 25
// taps indexed row*5+col (row 0 = oldest image row, col 0 = leftmost).
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 28,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           shift_en,
   input  logic [DATA_WIDTH-1:0]          pixel_in,
   output logic [KK-1:0][DATA_WIDTH-1:0]  taps
);
   localparam int unsigned FD = IMG_WIDTH - 1;

   logic [DATA_WIDTH-1:0] win  [K][K];
   logic [DATA_WIDTH-1:0] fifo [K-1][FD];

   // Each row delay line is fed from the newest column of the row below,
   // so window row r lags row r+1 by exactly one image row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < K; r++)
            for (int unsigned c = 0; c < K; c++)
               win[r][c] <= '0;
         for (int unsigned r = 0; r < K - 1; r++)
            for (int unsigned i = 0; i < FD; i++)
               fifo[r][i] <= '0;
      end else if (shift_en) begin
         for (int unsigned r = 0; r < K; r++)
            for (int unsigned c = 0; c < K - 1; c++)
               win[r][c] <= win[r][c+1];
         for (int unsigned r = 0; r < K - 1; r++) begin
            win[r][K-1] <= fifo[r][FD-1];
            fifo[r][0]  <= win[r+1][K-1];
            for (int unsigned i = 1; i < FD; i++)
               fifo[r][i] <= fifo[r][i-1];
         end
         win[K-1][K-1] <= pixel_in;
      end
   end

   // Flatten the window into the tap vector.
   always_comb begin
      for (int unsigned r = 0; r < K; r++)
         for (int unsigned c = 0; c < K; c++)
            taps[r*K+c] = win[r][c];
   end

endmodule

// File: rtl/conv_multich_accel.sv
// Streaming 5x5 convolution, NUM_CH output channels time-multiplexed over
// one pipelined 25-tap MAC. Optional macro CONV_RELU_EN clamps negative
// results to zero after saturation.
module conv_multich_accel
   import conv_pkg::*;
#(
   parameter int unsigned IMG_WIDTH    = 28,
   parameter int unsigned IMG_HEIGHT   = 28,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned WEIGHT_WIDTH = 8,
   parameter int unsigned OUT_WIDTH    = 32,
   parameter int unsigned NUM_CH       = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   conv_multich_accel_if.slave bus
);
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned COL_W = $clog2(IMG_WIDTH);
   localparam int unsigned ROW_W = $clog2(IMG_HEIGHT) + 1;
   localparam int unsigned PW    = DATA_WIDTH + WEIGHT_WIDTH + 1;
   localparam int unsigned SW    = PW + 5;
   localparam int unsigned AW    = acc_w(SW);

   conv_state_e state, state_nxt;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [CH_W-1:0]  ch_cnt;
   logic             last_win;

   logic signed [WEIGHT_WIDTH-1:0] weight [NUM_CH][KK];
   logic signed [31:0]             bias   [NUM_CH];
   logic                           cfg_err_q;

   logic [KK-1:0][DATA_WIDTH-1:0] taps;

   logic                v0, v1, v2;
   logic [CH_W-1:0]     ch0, ch1, ch2;
   logic                l0, l1, l2;
   logic signed [PW-1:0] prod [KK];
   logic signed [SW-1:0] sum2, sum_c;
   logic signed [AW-1:0] acc_c;
   logic signed [SAT_W-1:0] sat_c;
   logic signed [OUT_WIDTH-1:0] res_c;

   logic                        out_valid_q;
   logic signed [OUT_WIDTH-1:0] out_data_q;
   logic [CH_W-1:0]             out_ch_q;
   logic                        out_last_q;

   logic stall, adv, in_ready_c, accept, win_hit, frame_end_pix, ch_wrap;

   assign stall         = out_valid_q && !bus.out_ready;
   assign adv           = !stall;
   assign accept        = bus.in_valid && in_ready_c;
   assign win_hit       = accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
   assign frame_end_pix = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));
   assign ch_wrap       = (ch_cnt == CH_W'(NUM_CH - 1));

   conv_line_buffer #(
      .IMG_WIDTH  (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_line_buffer (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (accept),
      .pixel_in (bus.pixel_in),
      .taps     (taps)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = win_hit ? COMPUTE : ACCEPT;
         ACCEPT:  if (win_hit) state_nxt = COMPUTE;
         COMPUTE: if (adv && ch_wrap) state_nxt = last_win ? DRAIN : ACCEPT;
         DRAIN:   if (out_valid_q && bus.out_ready && out_last_q) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: pixel ready is held low during reset and while stalled.
   always_comb begin
      in_ready_c     = rst_n && !stall && ((state == IDLE) || (state == ACCEPT));
      bus.in_ready   = in_ready_c;
      bus.frame_busy = (state != IDLE);
   end

   // Pixel position, channel issue counter and last-window flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col      <= '0;
         row      <= '0;
         ch_cnt   <= '0;
         last_win <= 1'b0;
      end else if ((state == DRAIN) && (state_nxt == IDLE)) begin
         col      <= '0;
         row      <= '0;
         ch_cnt   <= '0;
         last_win <= 1'b0;
      end else begin
         if (accept) begin
            if (col == COL_W'(IMG_WIDTH - 1)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (win_hit) last_win <= frame_end_pix;
         if ((state == COMPUTE) && adv) ch_cnt <= ch_wrap ? '0 : ch_cnt + 1'b1;
      end
   end

   // Weight/bias register file; writes outside IDLE are dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err_q <= 1'b0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            bias[c] <= '0;
            for (int unsigned i = 0; i < KK; i++) weight[c][i] <= '0;
         end
      end else begin
         cfg_err_q <= 1'b0;
         if (bus.cfg_we && (bus.cfg_idx <= 5'(CFG_BIAS_IDX))) begin
            if (state != IDLE) begin
               cfg_err_q <= 1'b1;
            end else if (32'(bus.cfg_ch) < NUM_CH) begin
               if (bus.cfg_idx == 5'(CFG_BIAS_IDX)) bias[bus.cfg_ch] <= bus.cfg_data;
               else weight[bus.cfg_ch][bus.cfg_idx] <= bus.cfg_data[WEIGHT_WIDTH-1:0];
            end
         end
      end
   end

   // Adder tree over the registered products.
   always_comb begin
      sum_c = '0;
      for (int unsigned i = 0; i < KK; i++) sum_c = sum_c + SW'(prod[i]);
   end

   // Bias add, saturation and optional ReLU feeding the output register.
   always_comb begin
      acc_c = AW'(sum2) + AW'(bias[ch2]);
      sat_c = saturate(SAT_W'(acc_c), OUT_WIDTH);
`ifdef CONV_RELU_EN
      if (sat_c < 0) sat_c = '0;
`else
      sat_c = sat_c;
`endif
      res_c = sat_c[OUT_WIDTH-1:0];
   end

   // Issue, multiply, adder-tree and output stages; all freeze on stall.
   // The window may shift on the same edge the multiply stage samples it,
   // which is safe because the multiply captures the pre-shift taps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
         ch0 <= '0;  ch1 <= '0;  ch2 <= '0;
         l0 <= 1'b0; l1 <= 1'b0; l2 <= 1'b0;
         for (int unsigned i = 0; i < KK; i++) prod[i] <= '0;
         sum2        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
      end else if (adv) begin
         v0  <= (state == COMPUTE);
         ch0 <= ch_cnt;
         l0  <= (state == COMPUTE) && last_win && ch_wrap;
         v1  <= v0;
         ch1 <= ch0;
         l1  <= l0;
         for (int unsigned i = 0; i < KK; i++)
            prod[i] <= PW'($signed({1'b0, taps[i]})) * PW'(weight[ch0][i]);
         v2   <= v1;
         ch2  <= ch1;
         l2   <= l1;
         sum2 <= sum_c;
         out_valid_q <= v2;
         out_data_q  <= res_c;
         out_ch_q    <= ch2;
         out_last_q  <= v2 && l2;
      end
   end

   assign bus.cfg_err   = cfg_err_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_conv_multich_accel.sv
// Randomized self-checking bench for conv_multich_accel against a direct
// 5x5 convolution reference model. Honours CONV_RELU_EN like the design.
module tb_conv_multich_accel;

   localparam int W   = 28;
   localparam int H   = 28;
   localparam int NC  = 4;
   localparam int OW  = 32;
   localparam int NOUT = (W - 4) * (H - 4) * NC;

   typedef struct {
      longint data;
      int     ch;
      bit     last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_multich_accel_if #(.DATA_WIDTH(8), .OUT_WIDTH(OW), .CH_W(2)) bus ();

   conv_multich_accel #(
      .IMG_WIDTH    (W),
      .IMG_HEIGHT   (H),
      .DATA_WIDTH   (8),
      .WEIGHT_WIDTH (8),
      .OUT_WIDTH    (OW),
      .NUM_CH       (NC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int     n_chk = 0;
   int     n_bad = 0;
   int     wt  [NC][25];
   longint bs  [NC];
   int     img [H][W];
   exp_t   exp_q [$];
   exp_t   e;

   int  cyc = 0;
   bit  sb_en = 1'b1;
   bit  lat_en = 1'b0;
   int  rdy_mode = 0;
   bit  stall_done = 1'b0;
   int  n_out, n_last, acc_cnt, t_win;
   bit  first_seen;
   longint first_data;
   bit  prev_stall = 1'b0;
   logic signed [OW-1:0] prev_data;
   logic [1:0] prev_ch;
   logic prev_last;

   task automatic check_eq(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Reference: direct convolution of the stored frame, saturate, optional ReLU.
   function automatic longint model_out(input int r, input int c, input int ch);
      longint acc;
      acc = bs[ch];
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            acc += longint'(img[r-4+i][c-4+j]) * longint'(wt[ch][i*5+j]);
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      return acc;
   endfunction

   task automatic build_expected();
      exp_t x;
      exp_q.delete();
      for (int r = 4; r < H; r++)
         for (int c = 4; c < W; c++)
            for (int ch = 0; ch < NC; ch++) begin
               x.data = model_out(r, c, ch);
               x.ch   = ch;
               x.last = (r == H - 1) && (c == W - 1) && (ch == NC - 1);
               exp_q.push_back(x);
            end
   endtask

   task automatic fill_img(input int mode);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (mode)
               0:       img[r][c] = (r * 28 + c) & 255;
               1:       img[r][c] = 255;
               default: img[r][c] = int'($urandom_range(0, 255));
            endcase
   endtask

   task automatic model_write(input int ch, input int idx, input logic [31:0] data);
      logic signed [7:0]  w8;
      logic signed [31:0] b32;
      w8  = data[7:0];
      b32 = data;
      if (idx < 25) wt[ch][idx] = w8;
      else if (idx == 25) bs[ch] = b32;
   endtask

   // Starts and ends at posedge+2.
   task automatic cfg_write(input int ch, input int idx, input logic [31:0] data,
                            input bit exp_err);
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = 2'(ch);
      bus.cfg_idx  = 5'(idx);
      bus.cfg_data = data;
      @(posedge clk); #2;
      bus.cfg_we = 1'b0;
      @(negedge clk);
      check_eq("cfg_err", bus.cfg_err, exp_err);
      if (exp_err) begin
         @(negedge clk);
         check_eq("cfg_err_pulse", bus.cfg_err, 0);
      end else begin
         model_write(ch, idx, data);
      end
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      exp_q.delete();
      for (int c = 0; c < NC; c++) begin
         bs[c] = 0;
         for (int i = 0; i < 25; i++) wt[c][i] = 0;
      end
      @(negedge clk);
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_out_data", bus.out_data, 0);
      check_eq("rst_out_ch", bus.out_ch, 0);
      check_eq("rst_out_last", bus.out_last, 0);
      check_eq("rst_frame_busy", bus.frame_busy, 0);
      check_eq("rst_cfg_err", bus.cfg_err, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_in_ready", bus.in_ready, 1);
      @(posedge clk); #2;
   endtask

   // Drives npix pixels of img in raster order; optional random gaps and an
   // optional config write coincident with the first pixel.
   task automatic send_frame(input int npix, input bit gaps, input bit first_cfg,
                             input int cch, input int cidx, input logic [31:0] cdata);
      bit acc;
      for (int p = 0; p < npix; p++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               bus.in_valid = 1'b0;
               @(posedge clk); #2;
            end
         end
         bus.in_valid = 1'b1;
         bus.pixel_in = 8'(img[p / W][p % W]);
         if (first_cfg && p == 0) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_ch   = 2'(cch);
            bus.cfg_idx  = 5'(cidx);
            bus.cfg_data = cdata;
         end
         acc = 1'b0;
         for (int g = 0; g < 5000 && !acc; g++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #2;
         end
         bus.cfg_we = 1'b0;
         if (!acc) begin
            check_eq("in_ready_wait", 0, 1);
            bus.in_valid = 1'b0;
            return;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic start_frame_stats();
      n_out = 0;
      n_last = 0;
      first_seen = 1'b0;
      first_data = 0;
      stall_done = 1'b0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 30000) begin
         @(posedge clk); #2;
         g++;
      end
      check_eq("drain_left", exp_q.size(), 0);
      @(negedge clk);
      check_eq("busy_after_frame", bus.frame_busy, 0);
      check_eq("frame_out_count", n_out, NOUT);
      check_eq("frame_last_count", n_last, 1);
      @(posedge clk); #2;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready generator.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
               bus.out_ready = 1'b1;
               if (!stall_done && bus.out_valid && bus.out_ch == 2'd1) begin
                  bus.out_ready = 1'b0;
                  repeat (10) begin @(posedge clk); #2; end
                  bus.out_ready = 1'b1;
                  stall_done = 1'b1;
               end
            end
         endcase
      end
   end

   // Scoreboard, stall-hold and latency monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else if (sb_en) begin
         if (prev_stall) begin
            check_eq("hold_valid", bus.out_valid, 1);
            check_eq("hold_data", bus.out_data, prev_data);
            check_eq("hold_ch", bus.out_ch, prev_ch);
            check_eq("hold_last", bus.out_last, prev_last);
         end
         if (bus.out_valid && !bus.out_ready)
            check_eq("stall_in_ready", bus.in_ready, 0);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("out_data", bus.out_data, e.data);
               check_eq("out_ch", bus.out_ch, e.ch);
               check_eq("out_last", bus.out_last, e.last);
               if (!first_seen) begin
                  first_seen = 1'b1;
                  first_data = bus.out_data;
               end
               n_out++;
               if (bus.out_last) n_last++;
            end
         end
         if (!bus.frame_busy) acc_cnt = 0;
         if (lat_en && acc_cnt >= 4 * W + 5 && t_win >= 0 && bus.out_valid) begin
            check_eq("latency_ch0", cyc - t_win, 4);
            t_win = -1;
         end
         if (bus.in_valid && bus.in_ready) begin
            acc_cnt++;
            if (acc_cnt == 4 * W + 5) t_win = cyc + 1;
         end
         prev_stall <= bus.out_valid && !bus.out_ready;
         prev_data  <= bus.out_data;
         prev_ch    <= bus.out_ch;
         prev_last  <= bus.out_last;
      end
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.pixel_in = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_idx  = '0;
      bus.cfg_data = '0;
      acc_cnt = 0;
      t_win = -1;
      @(posedge clk); #2;
      do_reset();

      // Frame 0: centre tap only on ch0, ramp image, latency check.
      cfg_write(0, 12, 32'd1, 1'b0);
      fill_img(0);
      build_expected();
      start_frame_stats();
      lat_en = 1'b1;
      t_win = -1;
      rdy_mode = 0;
      send_frame(W * H, 1'b0, 1'b0, 0, 0, 0);
      wait_drain();
      check_eq("ramp_first_out", first_data, 58);
      lat_en = 1'b0;

      // Frame 1: all ones, bias -100, flat 255 image, one 10-cycle stall.
      for (int c = 0; c < NC; c++) begin
         for (int i = 0; i < 25; i++) cfg_write(c, i, 32'd1, 1'b0);
         cfg_write(c, 25, -32'sd100, 1'b0);
      end
      fill_img(1);
      build_expected();
      start_frame_stats();
      rdy_mode = 2;
      send_frame(W * H, 1'b0, 1'b0, 0, 0, 0);
      wait_drain();
      check_eq("flat_first_out", first_data, 6275);
      check_eq("stall_happened", stall_done, 1);

      // Frame 2: saturation corners on ch0/ch1, plain negative sum on ch2.
      for (int i = 0; i < 25; i++) begin
         cfg_write(0, i, 32'hFFFF_FF80, 1'b0);
         cfg_write(1, i, 32'd127, 1'b0);
         cfg_write(2, i, 32'hFFFF_FF80, 1'b0);
      end
      cfg_write(0, 25, 32'h8000_0000, 1'b0);
      cfg_write(1, 25, 32'h7FFF_FFFF, 1'b0);
      cfg_write(2, 25, 32'd0, 1'b0);
      cfg_write(3, 28, 32'd999, 1'b0);
      fill_img(1);
      build_expected();
      start_frame_stats();
      rdy_mode = 1;
      send_frame(W * H, 1'b1, 1'b0, 0, 0, 0);
      wait_drain();

      // Frame 3a: random config, writes during the frame must be dropped.
      for (int c = 0; c < NC; c++) begin
         for (int i = 0; i < 25; i++) cfg_write(c, i, $urandom, 1'b0);
         cfg_write(c, 25, 32'($urandom_range(0, 2000000)) - 32'd1000000, 1'b0);
      end
      fill_img(2);
      build_expected();
      start_frame_stats();
      rdy_mode = 1;
      fork
         send_frame(W * H, 1'b1, 1'b0, 0, 0, 0);
         begin
            repeat (300) begin @(posedge clk); #2; end
            cfg_write(2, 7, 32'h0000_0055, 1'b1);
            cfg_write(1, 25, 32'd424242, 1'b1);
            cfg_write(0, 30, 32'd7, 1'b0);
         end
      join
      wait_drain();

      // Frame 3b: same weights; bias write lands with the first pixel.
      fill_img(2);
      model_write(3, 25, 32'd12345);
      build_expected();
      start_frame_stats();
      send_frame(W * H, 1'b1, 1'b1, 3, 25, 32'd12345);
      wait_drain();

      // Frame 4: abort mid-frame with reset, then rerun with cleared weights.
      for (int c = 0; c < NC; c++) cfg_write(c, 25, 32'd1000, 1'b0);
      fill_img(2);
      sb_en = 1'b0;
      send_frame(400, 1'b0, 1'b0, 0, 0, 0);
      repeat (3) begin @(posedge clk); #2; end
      do_reset();
      sb_en = 1'b1;
      fill_img(2);
      build_expected();
      start_frame_stats();
      rdy_mode = 1;
      send_frame(W * H, 1'b1, 1'b0, 0, 0, 0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
